// File: rtl/qspi_xip_line_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : qspi_xip_line_cache_if
// Brief    : AHB-Lite slave-slot signal bundle for the XIP line cache.
// Revision : 1.0 - initial release
// ============================================================================
interface qspi_xip_line_cache_if #(
    parameter int ADDR_W = 24
);
    logic              HSEL;
    logic              HREADY;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [ADDR_W-1:0] HADDR;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;

    modport master (
        output HSEL, HREADY, HTRANS, HWRITE, HADDR,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HREADY, HTRANS, HWRITE, HADDR,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface
`default_nettype wire

// File: rtl/qspi_xip_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : qspi_xip_line_cache
// Brief    : Read-only direct-mapped line cache in front of the QSPI XIP reader.
//            Optional hit/miss counters with QSPI_XIP_CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_xip_line_cache #(
    parameter int NUM_LINES  = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 24
) (
    input  wire logic              HCLK,
    input  wire logic              HRESETn,
    qspi_xip_line_cache_if.slave   ahb,
    input  wire logic              flush,
    output logic                   fill_req,
    output logic [ADDR_W-1:0]      fill_addr,
    input  wire logic              fill_valid,
    input  wire logic [31:0]       fill_rdata
`ifdef QSPI_XIP_CACHE_STATS_EN
    ,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);

    localparam int c_WORD_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W   = $clog2(NUM_LINES);
    localparam int c_TAG_LSB = 2 + c_WORD_W + c_IDX_W;
    localparam int c_TAG_W   = ADDR_W - c_TAG_LSB;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        RESP   = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [31:0]             r_hrdata;
    logic                    r_fill_req;
    logic [ADDR_W-1:0]       r_fill_addr;
    logic [c_WORD_W-1:0]     r_cnt;
    logic [c_TAG_W-1:0]      r_tag;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_WORD_W-1:0]     r_word;
    logic                    r_flush_pend;
    logic [NUM_LINES-1:0]    r_valid;
    logic [c_TAG_W-1:0]      r_tag_mem  [NUM_LINES];
    logic [31:0]             r_data_mem [NUM_LINES*LINE_WORDS];

    logic                    w_accept;
    logic [c_WORD_W-1:0]     w_word;
    logic [c_IDX_W-1:0]      w_idx;
    logic [c_TAG_W-1:0]      w_tag;
    logic                    w_hit;
    logic                    w_last;
    logic                    w_fill_done;
    logic                    w_unused_bits;

    assign w_accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign w_word      = ahb.HADDR[c_WORD_W+1:2];
    assign w_idx       = ahb.HADDR[c_TAG_LSB-1:c_WORD_W+2];
    assign w_tag       = ahb.HADDR[ADDR_W-1:c_TAG_LSB];
    assign w_hit       = r_valid[w_idx] & (r_tag_mem[w_idx] == w_tag);
    assign w_last      = (r_cnt == c_WORD_W'(LINE_WORDS - 1));
    assign w_fill_done = (r_state == FILL) & fill_valid & w_last;
    assign w_unused_bits = &{1'b0, ahb.HADDR[1:0], ahb.HTRANS[0]};

    assign ahb.HREADYOUT = r_hreadyout;
    assign ahb.HRESP     = r_hresp;
    assign ahb.HRDATA    = r_hrdata;
    assign fill_req      = r_fill_req;
    assign fill_addr     = r_fill_addr;

    // Lookup happens on the address-phase edge so a hit's data is registered
    // and presented in the very first data-phase cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= IDLE;
            r_hreadyout  <= 1'b1;
            r_hresp      <= 1'b0;
            r_hrdata     <= '0;
            r_fill_req   <= 1'b0;
            r_fill_addr  <= '0;
            r_cnt        <= '0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (fill_valid) begin
                        if (r_cnt == r_word) r_hrdata <= fill_rdata;
                        r_cnt <= r_cnt + c_WORD_W'(1);
                        if (w_last) begin
                            r_state      <= RESP;
                            r_hreadyout  <= 1'b1;
                            r_fill_req   <= 1'b0;
                            r_flush_pend <= 1'b0;
                        end
                    end
                end
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    if (w_accept) begin
                        r_tag  <= w_tag;
                        r_idx  <= w_idx;
                        r_word <= w_word;
                        if (ahb.HWRITE) begin
                            r_state     <= ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else if (w_hit) begin
                            r_state  <= LOOKUP;
                            r_hrdata <= r_data_mem[{w_idx, w_word}];
                        end else begin
                            r_state     <= FILL;
                            r_hreadyout <= 1'b0;
                            r_fill_req  <= 1'b1;
                            r_fill_addr <= {w_tag, w_idx, {(c_WORD_W+2){1'b0}}};
                        end
                    end
                end
            endcase
        end
    end

    // A flush seen at any point of a fill keeps the freshly filled line invalid.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_fill_done && !r_flush_pend) begin
            r_valid[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (r_state == FILL && fill_valid) begin
            r_data_mem[{r_idx, r_cnt}] <= fill_rdata;
            if (w_last) r_tag_mem[r_idx] <= r_tag;
        end
    end

`ifdef QSPI_XIP_CACHE_STATS_EN
    logic w_hit_evt;

    assign w_hit_evt = (r_state != FILL) && (r_state != ERR1) && w_accept
                       && !ahb.HWRITE && w_hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (flush) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_hit_evt && hit_cnt != 32'hFFFF_FFFF)     hit_cnt  <= hit_cnt + 32'd1;
            if (w_fill_done && miss_cnt != 32'hFFFF_FFFF)  miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qspi_xip_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_xip_line_cache
// Brief    : Directed self-checking bench for qspi_xip_line_cache with a data queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_xip_line_cache;

    logic        HCLK;
    logic        HRESETn;
    logic        flush;
    logic        fill_req;
    logic [23:0] fill_addr;
    logic        fill_valid;
    logic [31:0] fill_rdata;
`ifdef QSPI_XIP_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_data;

    qspi_xip_line_cache_if #(.ADDR_W(24)) bus ();

    // Single slave on the bus: the global HREADY is this slave's HREADYOUT.
    assign bus.HREADY = bus.HREADYOUT;

    qspi_xip_line_cache #(
        .NUM_LINES  (32),
        .LINE_WORDS (4),
        .ADDR_W     (24)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .ahb        (bus.slave),
        .flush      (flush),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_valid (fill_valid),
        .fill_rdata (fill_rdata)
`ifdef QSPI_XIP_CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] flash(input logic [23:0] a);
        return {8'hA5, a[23:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic drive(input logic [23:0] a, input logic wr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HADDR  = a;
    endtask

    task automatic rd_hit(input logic [23:0] a);
        logic [31:0] e;
        drive(a, 1'b0);
        exp_q.push_back(flash(a));
        @(posedge HCLK); @(negedge HCLK);
        bus_idle();
        chk("hit_ready", bus.HREADYOUT, 1);
        chk("hit_resp", bus.HRESP, 0);
        chk("hit_fill_req", fill_req, 0);
        e = exp_q.pop_front();
        chk("hit_data", bus.HRDATA, e);
        last_data = e;
    endtask

    task automatic rd_miss(input logic [23:0] a, input int gap, input int flush_word);
        logic [23:0] base;
        logic [31:0] e;
        base = {a[23:4], 4'h0};
        drive(a, 1'b0);
        exp_q.push_back(flash(a));
        @(posedge HCLK); @(negedge HCLK);
        bus_idle();
        chk("miss_ready", bus.HREADYOUT, 0);
        chk("miss_fill_req", fill_req, 1);
        chk("miss_fill_addr", fill_addr, base);
        repeat (gap) begin
            @(negedge HCLK);
            chk("gap_ready", bus.HREADYOUT, 0);
        end
        for (int w = 0; w < 4; w++) begin
            fill_valid = 1'b1;
            fill_rdata = flash(base + 24'(4 * w));
            flush      = (w == flush_word);
            @(negedge HCLK);
            fill_valid = 1'b0;
            fill_rdata = 32'hDEAD_BEEF;
            flush      = 1'b0;
            if (w < 3) begin
                chk("fill_ready", bus.HREADYOUT, 0);
                chk("fill_req_hold", fill_req, 1);
            end
        end
        chk("resp_ready", bus.HREADYOUT, 1);
        chk("resp_resp", bus.HRESP, 0);
        chk("resp_fill_req", fill_req, 0);
        e = exp_q.pop_front();
        chk("resp_data", bus.HRDATA, e);
        last_data = e;
    endtask

    task automatic wr_err(input logic [23:0] a);
        drive(a, 1'b1);
        @(posedge HCLK); @(negedge HCLK);
        bus_idle();
        chk("err1_ready", bus.HREADYOUT, 0);
        chk("err1_resp", bus.HRESP, 1);
        @(negedge HCLK);
        chk("err2_ready", bus.HREADYOUT, 1);
        chk("err2_resp", bus.HRESP, 1);
        @(negedge HCLK);
        chk("err_done_resp", bus.HRESP, 0);
    endtask

    task automatic rd_reset(input logic [23:0] a);
        logic [23:0] base;
        base = {a[23:4], 4'h0};
        drive(a, 1'b0);
        exp_q.push_back(flash(a));
        @(posedge HCLK); @(negedge HCLK);
        bus_idle();
        chk("rst_fill_req_pre", fill_req, 1);
        for (int w = 0; w < 2; w++) begin
            fill_valid = 1'b1;
            fill_rdata = flash(base + 24'(4 * w));
            @(negedge HCLK);
            fill_valid = 1'b0;
        end
        HRESETn = 1'b0;
        #1;
        chk("rst_fill_req", fill_req, 0);
        chk("rst_ready", bus.HREADYOUT, 1);
        chk("rst_resp", bus.HRESP, 0);
        chk("rst_rdata", bus.HRDATA, 0);
        void'(exp_q.pop_back());
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn    = 1'b0;
        flush      = 1'b0;
        fill_valid = 1'b0;
        fill_rdata = '0;
        bus.HADDR  = '0;
        bus_idle();
        last_data  = '0;
        repeat (2) @(negedge HCLK);
        chk("reset_ready", bus.HREADYOUT, 1);
        chk("reset_resp", bus.HRESP, 0);
        chk("reset_rdata", bus.HRDATA, 0);
        chk("reset_fill_req", fill_req, 0);
        chk("reset_fill_addr", fill_addr, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Cold miss, then an immediate hit in the same line
        rd_miss(24'h000104, 1, -1);
        rd_hit(24'h000108);
`ifdef QSPI_XIP_CACHE_STATS_EN
        chk("stats_hit", hit_cnt, 1);
        chk("stats_miss", miss_cnt, 1);
`endif

        // Selected IDLE transfer: no wait, OKAY, HRDATA holds
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b00;
        bus.HADDR  = 24'h000300;
        @(posedge HCLK); @(negedge HCLK);
        bus_idle();
        chk("idle_ready", bus.HREADYOUT, 1);
        chk("idle_resp", bus.HRESP, 0);
        chk("idle_hold", bus.HRDATA, last_data);
        chk("idle_fill_req", fill_req, 0);

        // Conflict eviction in index 16
        rd_miss(24'h000304, 0, -1);
        rd_miss(24'h000104, 2, -1);

        // Write error, cache untouched
        wr_err(24'h000010);
        rd_hit(24'h00010C);

        // Top of the flash window, last line index
        rd_miss(24'hFFFFFC, 0, -1);
        rd_hit(24'hFFFFF0);

        // Flush on the second fill word: data returned, line left invalid
        rd_miss(24'h000208, 0, 1);
        rd_miss(24'h000208, 0, -1);
        rd_hit(24'h000200);

        // Reset mid-fill, then a previously valid line misses
        rd_reset(24'h000104);
        rd_miss(24'h000204, 0, -1);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
